// File: rtl/tc_io_pkg.sv
// Shared types and constants for the IO pad multiplexer.
//   funcsel_t   - 2-bit function select; function 0 is GPIO
//   REG_*       - word addresses of the register port
//   pad_state_e - per-pad sequencer state
package tc_io_pkg;

    typedef logic [1:0] funcsel_t;

    localparam logic [1:0] REG_FUNCSEL = 2'd0;
    localparam logic [1:0] REG_BUSY    = 2'd1;
    localparam logic [1:0] REG_PADIN   = 2'd2;

    typedef enum logic {
        ACTIVE = 1'b0,
        TURN   = 1'b1
    } pad_state_e;

endpackage

// File: rtl/tc_io_pad_seq.sv
// One pad's function sequencer: current/requested function, high-Z turnaround
// counter and the output/input muxes.
//   clk_i, rst_n_i   - clock, async active-low reset
//   wr_i, wr_sel_i   - accepted FUNCSEL write carrying a legal field for this pad
//   fn_c2p_i/fn_oe_i - per-function output data / enable for this pad
//   sync_i           - synchronised pad input
//   fn_p2c_o         - pad input routed to the selected function only
//   pad_c2p_o/pad_c2p_en_o - pad drive data / enable
//   busy_o           - pad is in its turnaround window
//   sel_o            - requested function (software readback view)
module tc_io_pad_seq
    import tc_io_pkg::*;
#(
    parameter int unsigned NUM_FUNC = 4,
    parameter int unsigned TURN_CYC = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wr_i,
    input  logic [1:0]          wr_sel_i,
    input  logic [NUM_FUNC-1:0] fn_c2p_i,
    input  logic [NUM_FUNC-1:0] fn_oe_i,
    input  logic                sync_i,
    output logic [NUM_FUNC-1:0] fn_p2c_o,
    output logic                pad_c2p_o,
    output logic                pad_c2p_en_o,
    output logic                busy_o,
    output logic [1:0]          sel_o
);

    localparam logic [7:0] TurnLoad = 8'(TURN_CYC);

    pad_state_e state_q, state_d;
    funcsel_t   cur_q, cur_d;
    funcsel_t   nxt_q, nxt_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACTIVE: begin
                if (wr_i && (wr_sel_i != cur_q)) begin
                    nxt_d   = wr_sel_i;
                    cnt_d   = TurnLoad;
                    state_d = TURN;
                end
            end
            TURN: begin
                // Any write while turning restarts the window, even one back to cur.
                if (wr_i) begin
                    nxt_d = wr_sel_i;
                    cnt_d = TurnLoad;
                end else if (cnt_q == 8'd1) begin
                    cur_d   = nxt_q;
                    state_d = ACTIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ACTIVE;
            cur_q   <= '0;
            nxt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive and input routing only while ACTIVE; TURN forces high-Z and blocks p2c.
    always_comb begin
        pad_c2p_o    = 1'b0;
        pad_c2p_en_o = 1'b0;
        fn_p2c_o     = '0;
        if (state_q == ACTIVE) begin
            for (int unsigned f = 0; f < NUM_FUNC; f++) begin
                if (cur_q == 2'(f)) begin
                    pad_c2p_o    = fn_c2p_i[f];
                    pad_c2p_en_o = fn_oe_i[f];
                    fn_p2c_o[f]  = sync_i;
                end
            end
        end
    end

    assign busy_o = (state_q == TURN);
    assign sel_o  = nxt_q;

endmodule

// File: rtl/tc_io_pinmux_ctrl.sv
// Pad-ring function multiplexer: NUM_PAD sequencers, a 2-flop input
// synchroniser and a single-outstanding register port.
//   clk_i, rst_n_i        - clock, async active-low reset
//   cfg_*                 - register port (valid/ready, 2-bit word address)
//   fn_c2p_i/fn_oe_i      - function outputs, bit [f*NUM_PAD+p]
//   fn_p2c_o              - synchronised pad inputs per function, same packing
//   pad_c2p_o/pad_c2p_en_o/pad_p2c_i - pad ring connections
module tc_io_pinmux_ctrl
    import tc_io_pkg::*;
#(
    parameter int unsigned NUM_PAD  = 8,
    parameter int unsigned NUM_FUNC = 4,
    parameter int unsigned TURN_CYC = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cfg_valid_i,
    input  logic                         cfg_we_i,
    input  logic [1:0]                   cfg_addr_i,
    input  logic [31:0]                  cfg_wdata_i,
    output logic                         cfg_ready_o,
    output logic [31:0]                  cfg_rdata_o,
    input  logic [NUM_FUNC*NUM_PAD-1:0]  fn_c2p_i,
    input  logic [NUM_FUNC*NUM_PAD-1:0]  fn_oe_i,
    output logic [NUM_FUNC*NUM_PAD-1:0]  fn_p2c_o,
    output logic [NUM_PAD-1:0]           pad_c2p_o,
    output logic [NUM_PAD-1:0]           pad_c2p_en_o,
    input  logic [NUM_PAD-1:0]           pad_p2c_i
);

    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [NUM_PAD-1:0]   sync1_q, sync2_q;
    logic                 acc, wr_funcsel;
    logic [NUM_PAD-1:0]   pad_wr, busy;
    logic [31:0]          funcsel_rd;
    funcsel_t             sel_pad [NUM_PAD];
    logic [NUM_FUNC-1:0]  c2p_pad [NUM_PAD];
    logic [NUM_FUNC-1:0]  oe_pad  [NUM_PAD];
    logic [NUM_FUNC-1:0]  p2c_pad [NUM_PAD];

    // Ready is low on the cycle after each accept, so accepts are never back-to-back.
    assign acc        = cfg_valid_i & ~ready_q;
    assign wr_funcsel = acc & cfg_we_i & (cfg_addr_i == REG_FUNCSEL);

    // Regroup function-major packing into per-pad vectors and back.
    always_comb begin
        c2p_pad  = '{default: '0};
        oe_pad   = '{default: '0};
        fn_p2c_o = '0;
        for (int unsigned p = 0; p < NUM_PAD; p++) begin
            for (int unsigned f = 0; f < NUM_FUNC; f++) begin
                c2p_pad[p][f]              = fn_c2p_i[f*NUM_PAD+p];
                oe_pad[p][f]               = fn_oe_i[f*NUM_PAD+p];
                fn_p2c_o[f*NUM_PAD+p]      = p2c_pad[p][f];
            end
        end
    end

    for (genvar p = 0; p < NUM_PAD; p++) begin : g_pad
        // Out-of-range selects leave this pad's field untouched.
        assign pad_wr[p] = wr_funcsel & (32'(cfg_wdata_i[2*p +: 2]) < NUM_FUNC);

        tc_io_pad_seq #(
            .NUM_FUNC (NUM_FUNC),
            .TURN_CYC (TURN_CYC)
        ) u_seq (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .wr_i         (pad_wr[p]),
            .wr_sel_i     (cfg_wdata_i[2*p +: 2]),
            .fn_c2p_i     (c2p_pad[p]),
            .fn_oe_i      (oe_pad[p]),
            .sync_i       (sync2_q[p]),
            .fn_p2c_o     (p2c_pad[p]),
            .pad_c2p_o    (pad_c2p_o[p]),
            .pad_c2p_en_o (pad_c2p_en_o[p]),
            .busy_o       (busy[p]),
            .sel_o        (sel_pad[p])
        );
    end

    always_comb begin
        funcsel_rd = '0;
        for (int unsigned p = 0; p < NUM_PAD; p++) begin
            funcsel_rd[2*p +: 2] = sel_pad[p];
        end
    end

    always_comb begin
        ready_d = acc;
        rdata_d = '0;
        if (acc && !cfg_we_i) begin
            case (cfg_addr_i)
                REG_FUNCSEL: rdata_d = funcsel_rd;
                REG_BUSY:    rdata_d[NUM_PAD-1:0] = busy;
                REG_PADIN:   rdata_d[NUM_PAD-1:0] = sync2_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            sync1_q <= pad_p2c_i;
            sync2_q <= sync1_q;
        end
    end

    assign cfg_ready_o = ready_q;
    assign cfg_rdata_o = rdata_q;

endmodule

// File: tb/tb_tc_io_pinmux_ctrl.sv
module tb_tc_io_pinmux_ctrl;
    import tc_io_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0, cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_ready;
    logic [31:0] cfg_rdata;
    logic [31:0] fn_c2p = '0, fn_oe = '0, fn_p2c;
    logic [7:0]  pad_c2p, pad_en;
    logic [7:0]  pad_p2c = '0;

    logic        cfg3_valid = 1'b0, cfg3_we = 1'b0;
    logic [1:0]  cfg3_addr = '0;
    logic [31:0] cfg3_wdata = '0;
    logic        cfg3_ready;
    logic [31:0] cfg3_rdata;
    logic [11:0] fn3_c2p = '0, fn3_oe = '0, fn3_p2c;
    logic [3:0]  pad3_c2p, pad3_en;
    logic [3:0]  pad3_p2c = '0;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    tc_io_pinmux_ctrl #(.NUM_PAD(8), .NUM_FUNC(4), .TURN_CYC(4)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_ready_o(cfg_ready), .cfg_rdata_o(cfg_rdata),
        .fn_c2p_i(fn_c2p), .fn_oe_i(fn_oe), .fn_p2c_o(fn_p2c),
        .pad_c2p_o(pad_c2p), .pad_c2p_en_o(pad_en), .pad_p2c_i(pad_p2c)
    );

    tc_io_pinmux_ctrl #(.NUM_PAD(4), .NUM_FUNC(3), .TURN_CYC(4)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_valid_i(cfg3_valid), .cfg_we_i(cfg3_we), .cfg_addr_i(cfg3_addr),
        .cfg_wdata_i(cfg3_wdata), .cfg_ready_o(cfg3_ready), .cfg_rdata_o(cfg3_rdata),
        .fn_c2p_i(fn3_c2p), .fn_oe_i(fn3_oe), .fn_p2c_o(fn3_p2c),
        .pad_c2p_o(pad3_c2p), .pad_c2p_en_o(pad3_en), .pad_p2c_i(pad3_p2c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One register access; read expectations go through the scoreboard queue.
    task automatic cfg(input bit d3, input logic we, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input string tag);
        bit          got;
        logic [31:0] e;
        logic [31:0] rd;
        got = 1'b0;
        rd  = '0;
        if (!we) exp_q.push_back(exp);
        if (d3) begin
            cfg3_valid = 1'b1; cfg3_we = we; cfg3_addr = addr; cfg3_wdata = wdata;
        end else begin
            cfg_valid = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wdata;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            got = d3 ? cfg3_ready : cfg_ready;
            rd  = d3 ? cfg3_rdata : cfg_rdata;
        end
        cfg_valid  = 1'b0;
        cfg3_valid = 1'b0;
        check({tag, " ready"}, 32'(got), 32'd1);
        if (!we) begin
            e = exp_q.pop_front();
            check({tag, " rdata"}, rd, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lo;
        bit bad;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst en", pad_en, 8'h00);
        check("rst c2p", pad_c2p, 8'h00);
        check("rst p2c", fn_p2c, 32'h0);
        check("rst ready", cfg_ready, 1'b0);
        check("rst rdata", cfg_rdata, 32'h0);
        rst_n = 1'b1;
        cfg(0, 0, REG_FUNCSEL, 0, 32'h0, "rd funcsel0");
        cfg(0, 0, REG_BUSY, 0, 32'h0, "rd busy0");

        // GPIO pass-through
        fn_oe[7:0]  = 8'hFF;
        fn_c2p[7:0] = 8'hA5;
        #1;
        check("gpio c2p", pad_c2p, 8'hA5);
        check("gpio en", pad_en, 8'hFF);

        // pad1 -> func1: exactly TURN_CYC cycles undriven, other pads untouched
        fn_c2p[15:8] = 8'h02;
        fn_oe[15:8]  = 8'hFF;
        cfg(0, 1, REG_FUNCSEL, 32'h4, 0, "wr pad1");
        lo = 0; bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pad_en[1]) break;
            lo++;
            if (pad_c2p !== 8'hA5 || pad_en !== 8'hFD) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check("pad1 turn len", 32'(lo), 32'd4);
        check("pad1 turn others", 32'(bad), 32'd0);
        check("pad1 en after", pad_en, 8'hFF);
        check("pad1 c2p after", pad_c2p, 8'hA7);
        fn_c2p[7:0]  = 8'hFF;
        fn_c2p[15:8] = 8'h00;
        #1;
        check("pad1 follows f1", pad_c2p, 8'hFD);
        cfg(0, 0, REG_FUNCSEL, 0, 32'h4, "rd funcsel1");
        cfg(0, 0, REG_BUSY, 0, 32'h0, "rd busy1");

        // pad0 0->2, retarget to 3 two cycles later: window restarts
        fn_oe[23:16]  = 8'hFF;
        fn_oe[31:24]  = 8'hFF;
        fn_c2p[23:16] = 8'h01;
        fn_c2p[31:24] = 8'h00;
        cfg(0, 1, REG_FUNCSEL, 32'h6, 0, "wr pad0 f2");
        check("retgt en a", pad_en, 8'hFE);
        cfg(0, 1, REG_FUNCSEL, 32'h7, 0, "wr pad0 f3");
        check("retgt en b", pad_en, 8'hFE);
        cfg(0, 0, REG_BUSY, 0, 32'h1, "rd busy retgt");
        lo = 0; bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pad_en[0]) break;
            lo++;
            if (pad_c2p[0] !== 1'b0) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check("retgt tail len", 32'(lo), 32'd2);
        check("retgt c2p low", 32'(bad), 32'd0);
        check("retgt en end", pad_en, 8'hFF);
        check("retgt c2p end", pad_c2p, 8'hFC);
        cfg(0, 0, REG_FUNCSEL, 0, 32'h7, "rd funcsel retgt");

        // Input synchroniser: two-cycle latency, routed to selected function only
        pad_p2c = 8'h08;
        #1;
        check("sync lat0", fn_p2c, 32'h0);
        @(posedge clk);
        #1;
        check("sync lat1", fn_p2c, 32'h0);
        @(posedge clk);
        #1;
        check("sync lat2", fn_p2c, 32'h0000_0008);
        cfg(0, 0, REG_PADIN, 0, 32'h08, "rd padin");
        pad_p2c = 8'h09;
        repeat (2) @(posedge clk);
        #1;
        check("sync route", fn_p2c, 32'h0100_0008);

        // NUM_FUNC = 3: field 3 ignored, field 2 accepted
        cfg(1, 1, REG_FUNCSEL, 32'h30, 0, "wr3 inval");
        cfg(1, 0, REG_BUSY, 0, 32'h0, "rd3 busy inval");
        cfg(1, 0, REG_FUNCSEL, 0, 32'h0, "rd3 funcsel inval");
        cfg(1, 1, REG_FUNCSEL, 32'h20, 0, "wr3 val");
        cfg(1, 0, REG_BUSY, 0, 32'h4, "rd3 busy val");
        cfg(1, 0, REG_FUNCSEL, 0, 32'h20, "rd3 funcsel val");

        // Reset mid-TURN
        cfg(0, 1, REG_FUNCSEL, 32'hB, 0, "wr pad1 f2");
        fn_oe[7:0] = 8'h00;
        rst_n = 1'b0;
        #1;
        check("midrst en", pad_en, 8'h00);
        check("midrst p2c", fn_p2c, 32'h0);
        check("midrst ready", cfg_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg(0, 0, REG_FUNCSEL, 0, 32'h0, "rd funcsel rst");
        cfg(0, 0, REG_BUSY, 0, 32'h0, "rd busy rst");
        fn_oe[7:0]  = 8'hFF;
        fn_c2p[7:0] = 8'hA5;
        #1;
        check("rst gpio c2p", pad_c2p, 8'hA5);
        check("rst gpio en", pad_en, 8'hFF);

        // Reserved write ignored; readback shows requested value during TURN
        cfg(0, 1, 2'd3, 32'hFFFF_FFFF, 0, "wr rsvd");
        cfg(0, 0, REG_FUNCSEL, 0, 32'h0, "rd funcsel rsvd");
        cfg(0, 1, REG_FUNCSEL, 32'h1, 0, "wr pad0 f1");
        cfg(0, 0, REG_FUNCSEL, 0, 32'h1, "rd funcsel nxt");
        @(posedge clk);
        #1;
        check("rdata idle", cfg_rdata, 32'h0);
        check("ready idle", cfg_ready, 1'b0);

        // Valid held three cycles: ready on cycles 2 and 4 only
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold ready c%0d", i + 2), cfg_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            check($sformatf("hold rdata c%0d", i + 2), cfg_rdata, 32'h0);
            if (i == 2) cfg_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tc_io_pinmux_ctrl.md
Name: tc_io_pinmux_ctrl

Overview:
Per-pad function multiplexer and sequencer for the tri-state IO pad ring (c2p / c2p_en / p2c per pad). Shares each pad between NUM_FUNC peripheral functions under software control via a small register port. Switching a pad between functions goes through a forced-high-Z turnaround window, so two drivers never overlap. Pad inputs are synchronised into clk_i before they reach the functions and the register port. Sits between the pad-ring instances and the SoC peripherals.

Parameters:
NUM_PAD, 8, number of tri-state pads controlled (1..16).
NUM_FUNC, 4, functions per pad; function 0 is GPIO (fixed encoding 2 bits, so max 4).
TURN_CYC, 4, high-Z turnaround cycles on function change (1..255).

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  asynchronous active-low reset.
cfg_valid_i  in  1  register access request.
cfg_we_i  in  1  1 = write, 0 = read.
cfg_addr_i  in  2  word address.
cfg_wdata_i  in  32  write data.
cfg_ready_o  out  1  access accepted / read data valid.
cfg_rdata_o  out  32  read data.
fn_c2p_i  in  NUM_FUNC*NUM_PAD  function output data; bit [f*NUM_PAD+p].
fn_oe_i  in  NUM_FUNC*NUM_PAD  function output enable, same packing.
fn_p2c_o  out  NUM_FUNC*NUM_PAD  synchronised pad input to each function.
pad_c2p_o  out  NUM_PAD  to pad c2p.
pad_c2p_en_o  out  NUM_PAD  to pad c2p_en (1 = drive).
pad_p2c_i  in  NUM_PAD  from pad p2c (asynchronous).

Behaviour:
- Reset: all funcsel = 0 (GPIO), all pads ACTIVE, pad_c2p_en_o = 0, pad_c2p_o = 0, fn_p2c_o = 0, sync flops = 0, cfg_ready_o = 0, cfg_rdata_o = 0. Reset is async assert, sync deassert assumed upstream.
- Register map (word addr):
  - 0 FUNCSEL RW: bits [2p+1:2p] = function of pad p. Unused bits read 0. Values >= NUM_FUNC are ignored for that pad (field keeps old value).
  - 1 BUSY RO: bit p = pad p in TURN state.
  - 2 PADIN RO: synchronised pad inputs.
  - 3 reserved, reads 0, writes ignored.
- Handshake: cfg_ready_o pulses 1 cycle, exactly one cycle after each cycle in which cfg_valid_i = 1 and cfg_ready_o = 0. No back-to-back accepts; a master holds valid until ready. cfg_rdata_o is valid while ready = 1 and is 0 otherwise. The write takes effect on the accepting edge.
- Per-pad FSM, states ACTIVE and TURN:
  - ACTIVE: pad_c2p_o = fn_c2p_i[cur], pad_c2p_en_o = fn_oe_i[cur] (combinational from the function inputs). On a FUNCSEL write whose field differs from cur: latch nxt, load counter = TURN_CYC, go to TURN on the next cycle. Pad_c2p_en_o = 0 from that next cycle.
  - TURN: pad_c2p_en_o = 0, pad_c2p_o = 0, counter decrements each cycle. At counter = 1: cur <= nxt, go to ACTIVE. TURN therefore lasts exactly TURN_CYC cycles.
  - A write with the same field value has no effect.
  - A new write to a pad in TURN updates nxt and reloads the counter. If the new value equals cur, the pad still completes the reloaded TURN.
- Input path: 2-flop synchroniser per pad. fn_p2c_o[f][p] = sync[p] when f == cur[p] and the pad is ACTIVE, else 0. Latency from pad_p2c_i to fn_p2c_o is 2 cycles.
- Reset mid-TURN: the pad returns to ACTIVE, GPIO, undriven.
- FUNCSEL readback returns the requested nxt (software view), not cur.

Decomposition:
- Package tc_io_pkg: funcsel_t (2-bit), reg address constants REG_FUNCSEL/REG_BUSY/REG_PADIN, pad_state_e {ACTIVE, TURN}.
- Sub-module tc_io_pad_seq: one pad's FSM, turnaround counter and output mux.
- Top instantiates NUM_PAD copies, plus the synchroniser and register port.

Test Plan:
- Reset: assert rst_n_i = 0 mid-run -> all pad_c2p_en_o = 0 and FUNCSEL reads 0x0 after release. With fn_oe_i[0][*] = 1 and fn_c2p_i[0] = 0xA5, pad_c2p_o = 0xA5 and pad_c2p_en_o = 0xFF.
- Switch: write FUNCSEL = 0x0004 (pad1 -> func1) with TURN_CYC = 4 -> BUSY bit1 = 1 for exactly 4 cycles and pad_c2p_en_o[1] = 0 throughout. Afterwards pad1 follows fn_oe_i[1][1] and fn_c2p_i[1][1]; other pads are undisturbed.
- Input sync: toggle pad_p2c_i[3] -> fn_p2c_o[0][3] follows after 2 cycles, fn_p2c_o[1..3][3] stay 0, and PADIN bit3 matches.
- Retarget mid-TURN: pad0 0 -> 2, then 2 cycles later 0 -> 3 -> counter reloads, TURN lasts 2 + 4 cycles total, pad0 ends in func3, no enable glitch.
- Invalid select with NUM_FUNC = 3: write field 3 for pad2 -> field unchanged, no TURN entered.
- Handshake: hold cfg_valid_i for 3 cycles with reads of addr 3 -> ready pulses on cycles 2 and 4 only, rdata = 0.
